p_2mode_1: RTL and testbench
============================

Name: p_2mode_1

Overview:
- Parallel-side partner of the serial-interface transmitter/receiver; sits on the far end of the shared sen/sd link.
- Receive phase (updown=0): accepts 8 column frames (3-bit column address + 18 data bits) and writes each into its own 8x18 register bank.
- Send phase (updown=1): reads the bank back row by row and transmits 18 row frames (5-bit row address + 8 data bits), completing the transpose.
- Asserts P_done when the last row frame has gone out.

Parameters:
- COL_N, 8, number of column frames received and bank words.
- ROW_N, 18, number of row frames sent; bank word width.
- COL_AW, 3, column address bits in receive frame and RB_A width.
- ROW_AW, 5, row address bits in send frame.
- RECV_LEN, 21, receive frame length (COL_AW+ROW_N).
- SEND_LEN, 13, send frame length (ROW_AW+COL_N).

Ports:
- clk  in  1  clock; all state updates on falling edge.
- rst  in  1  asynchronous reset, active-low.
- updown  in  1  link direction: 0 = this block receives; 1 = this block drives sen/sd.
- P_done  out  1  send phase complete.
- RB_RW  out  1  bank access: 0 = write, 1 = read.
- RB_A  out  COL_AW  bank address.
- RB_D  out  ROW_N  bank write data.
- RB_Q  in  ROW_N  bank read data, valid one clk after RB_A/RB_RW=1 is presented.
- sen  inout  1  frame enable, active-low.
- sd  inout  1  serial data, MSB first.

Behaviour:
- Reset values: P_done=0, RB_RW=1, RB_A=0, RB_D=0, sen_out=1, sd_out=0, FSM=IDLE, all counters and shift registers 0.
- Tristate: drive sen/sd only when updown=1; otherwise high-Z.
- Input sampling: sen and sd are registered once before use.
- updown is registered once (updown_q); the FSM uses updown_q only.
- Frame format on the wire: sen low for exactly the frame length, one bit per clk, with at least 1 cycle of sen high between frames.
- FSM states: IDLE, RECV, RECV_WR, RECV_DONE, GATHER, SEND, SEND_GAP, SEND_DONE.
- IDLE: updown_q=0 -> RECV; updown_q=1 -> GATHER with row=0.
- RECV: each cycle with sampled sen=0, shift sampled sd into a 21-bit register and increment bit_cnt.
  - At bit_cnt=21 -> RECV_WR.
  - If sampled sen rises with 0<bit_cnt<21: discard the partial frame, clear bit_cnt, stay in RECV.
- RECV_WR (1 cycle): RB_RW=0, RB_A=reg[20:18], RB_D=reg[17:0]; first data bit received lands in word bit 17.
  - Increment col_cnt, clear bit_cnt.
  - col_cnt reaches 8 -> RECV_DONE; else -> RECV.
  - A repeated column address overwrites that word and still counts.
- RECV_DONE: wait for updown_q=1 -> GATHER with row=0, col_cnt=0.
- GATHER: issue reads to addresses 0..7 on consecutive cycles.
  - For each returned word k, load RB_Q[row] into byte bit k.
  - After word 7 is captured (9 cycles total) -> SEND with a 13-bit frame {row[4:0], byte[7:0]}.
- SEND: sen_out=0; shift the frame out MSB first for 13 cycles, then -> SEND_GAP.
- SEND_GAP (1 cycle, sen_out=1):
  - row<17: row+1, -> GATHER.
  - row=17: -> SEND_DONE.
- SEND_DONE: P_done=1, sen_out=1; hold until updown_q=0, then clear P_done, clear counters, -> RECV.
- updown_q changing mid-phase is ignored until the current phase's DONE state; sen/sd drive still follows the raw updown pin.
- Outside RECV_WR: RB_RW=1. Outside GATHER: RB_A=0.
- Asynchronous reset mid-frame aborts immediately to reset values; the next frame starts clean.

Decomposition:
- Shared package: frame lengths, COL_N/ROW_N, address widths, FSM state encoding (3 bits), updown direction constants; the same package serves the serial-side block.
- Sub-module: p_frame_shifter, a generic N-bit serial shift-in/shift-out register with bit counter and sen handling, instantiated once for receive (N=21) and once for send (N=13).

Test Plan:
- Receive 8 frames, column c with data 18'h2AAAA^c -> 8 writes, RB_A=c, RB_D=18'h2AAAA^c, one-cycle RB_RW=0 each.
- Full loop: bank preloaded column c = 18'h3FFFF>>c, updown=1 -> 18 frames; row r frame={r[4:0], byte}, byte bit k = bank[k][r]; P_done=1 after frame 17 plus 1 gap cycle.
- Partial frame: sen low for 10 bits then high, then a valid frame for column 5 -> only one write, RB_A=5.
- Drive check: updown=0 -> sen/sd high-Z from this block; updown=1 in SEND -> sen low exactly 13 cycles per frame, 10 clk high between frames (1 gap + 9 gather).
- Reset (rst=0) during row 9 of send -> all outputs at reset values immediately; after release with updown=1, sending restarts at row 0.
- P_done held while updown=1; clears one cycle after updown falls; the next receive frames are accepted.

Source files
------------

// File: rtl/p_2mode_1_pkg.sv
// Shared constants for the serial/parallel transpose link: frame geometry, link direction, FSM encoding.
// Used by both the parallel-side block and its serial-side partner.
package p_2mode_1_pkg;

    localparam int COL_N    = 8;
    localparam int ROW_N    = 18;
    localparam int COL_AW   = 3;
    localparam int ROW_AW   = 5;
    localparam int RECV_LEN = COL_AW + ROW_N;
    localparam int SEND_LEN = ROW_AW + COL_N;

    localparam logic DIR_RECV = 1'b0;
    localparam logic DIR_SEND = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        RECV_WR,
        RECV_DONE,
        GATHER,
        SEND,
        SEND_GAP,
        SEND_DONE
    } state_t;

endpackage

// File: rtl/p_2mode_1_frame_shifter.sv
// Generic N-bit serial shifter with bit counter; shifts sin in MSB-first while act and sen_n low.
// A frame whose sen_n rises before N bits is discarded; clr and load take priority over shifting.
module p_frame_shifter #(
    parameter int N  = 21,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          act,
    input  logic          sen_n,
    input  logic          sin,
    input  logic          clr,
    input  logic          load,
    input  logic [N-1:0]  load_dat,
    output logic [N-1:0]  dat,
    output logic [CW-1:0] cnt
);

    logic full;

    assign full = (cnt == CW'(N));

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            dat <= '0;
            cnt <= '0;
        end else if (clr) begin
            dat <= '0;
            cnt <= '0;
        end else if (load) begin
            dat <= load_dat;
            cnt <= '0;
        end else if (act && !sen_n && !full) begin
            dat <= {dat[N-2:0], sin};
            cnt <= cnt + 1'b1;
        end else if (act && sen_n && !full) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/p_2mode_1.sv
// Parallel-side transpose partner: receives 8 column frames into a bank, then sends 18 row frames back.
// All state moves on the falling clk edge; sen/sd are driven only while the raw updown pin is high.
module p_2mode_1
    import p_2mode_1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              updown,
    output logic              P_done,
    output logic              RB_RW,
    output logic [COL_AW-1:0] RB_A,
    output logic [ROW_N-1:0]  RB_D,
    input  logic [ROW_N-1:0]  RB_Q,
    inout  wire               sen,
    inout  wire               sd
);

    localparam int RX_CW  = $clog2(RECV_LEN + 1);
    localparam int TX_CW  = $clog2(SEND_LEN + 1);
    localparam int CNT_W  = $clog2(COL_N + 1);

    state_t               state, state_nxt;
    logic                 sen_q, sd_q, updown_q, armed;
    logic [ROW_AW-1:0]    row;
    logic [CNT_W-1:0]     col_cnt;
    logic [CNT_W-1:0]     gcnt;
    logic [COL_N-1:0]     gbyte;
    logic [RECV_LEN-1:0]  rx_dat;
    logic [RX_CW-1:0]     rx_cnt;
    logic [SEND_LEN-1:0]  tx_dat;
    logic [TX_CW-1:0]     tx_cnt;
    logic [SEND_LEN-1:0]  tx_frame;
    logic                 rx_clr, tx_load;
    logic                 sen_out, sd_out;
    logic                 unused_tx;

    assign sen = (updown == DIR_SEND) ? sen_out : 1'bz;
    assign sd  = (updown == DIR_SEND) ? sd_out  : 1'bz;

    assign rx_clr   = (state == RECV_WR) || (state == SEND_DONE);
    assign tx_load  = (state == GATHER) && (gcnt == CNT_W'(COL_N));
    // Word 7 arrives in the same cycle the frame is loaded, so it bypasses gbyte.
    assign tx_frame = {row, RB_Q[row], gbyte[COL_N-2:0]};
    assign unused_tx = ^tx_dat[SEND_LEN-2:0];

    p_frame_shifter #(.N(RECV_LEN), .CW(RX_CW)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .act      (state == RECV),
        .sen_n    (sen_q),
        .sin      (sd_q),
        .clr      (rx_clr),
        .load     (1'b0),
        .load_dat ('0),
        .dat      (rx_dat),
        .cnt      (rx_cnt)
    );

    p_frame_shifter #(.N(SEND_LEN), .CW(TX_CW)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .act      (state == SEND),
        .sen_n    (1'b0),
        .sin      (1'b0),
        .clr      (1'b0),
        .load     (tx_load),
        .load_dat (tx_frame),
        .dat      (tx_dat),
        .cnt      (tx_cnt)
    );

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sen_q    <= 1'b0;
            sd_q     <= 1'b0;
            updown_q <= 1'b0;
            armed    <= 1'b0;
            row      <= '0;
            col_cnt  <= '0;
            gcnt     <= '0;
            gbyte    <= '0;
        end else begin
            sen_q    <= sen;
            sd_q     <= sd;
            updown_q <= updown;
            armed    <= 1'b1;
            state    <= state_nxt;
            case (state)
                RECV_WR:   col_cnt <= col_cnt + 1'b1;
                RECV_DONE: if (state_nxt == GATHER) begin
                    row     <= '0;
                    col_cnt <= '0;
                    gcnt    <= '0;
                end
                GATHER: begin
                    gcnt <= gcnt + 1'b1;
                    if (gcnt != '0) gbyte[gcnt[COL_AW-1:0] - 1'b1] <= RB_Q[row];
                end
                SEND_GAP: begin
                    gcnt <= '0;
                    if (state_nxt == GATHER) row <= row + 1'b1;
                end
                SEND_DONE: if (state_nxt == RECV) begin
                    row     <= '0;
                    col_cnt <= '0;
                    gcnt    <= '0;
                    gbyte   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        P_done    = 1'b0;
        RB_RW     = 1'b1;
        RB_A      = '0;
        RB_D      = '0;
        sen_out   = 1'b1;
        sd_out    = 1'b0;
        unique case (state)
            // updown_q is only meaningful once it has been sampled after reset release.
            IDLE:      if (armed) state_nxt = (updown_q == DIR_SEND) ? GATHER : RECV;
            RECV:      if (!sen_q && rx_cnt == RX_CW'(RECV_LEN - 1)) state_nxt = RECV_WR;
            RECV_WR: begin
                RB_RW     = 1'b0;
                RB_A      = rx_dat[RECV_LEN-1:ROW_N];
                RB_D      = rx_dat[ROW_N-1:0];
                state_nxt = (col_cnt == CNT_W'(COL_N - 1)) ? RECV_DONE : RECV;
            end
            RECV_DONE: if (updown_q == DIR_SEND) state_nxt = GATHER;
            GATHER: begin
                RB_A = gcnt[COL_AW-1:0];
                if (gcnt == CNT_W'(COL_N)) state_nxt = SEND;
            end
            SEND: begin
                sen_out = 1'b0;
                sd_out  = tx_dat[SEND_LEN-1];
                if (tx_cnt == TX_CW'(SEND_LEN - 1)) state_nxt = SEND_GAP;
            end
            SEND_GAP:  state_nxt = (row == ROW_AW'(ROW_N - 1)) ? SEND_DONE : GATHER;
            SEND_DONE: begin
                P_done = 1'b1;
                if (updown_q == DIR_RECV) state_nxt = RECV;
            end
            default:   state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_p_2mode_1.sv
// Bench for p_2mode_1: bank model plus scoreboards for bank writes and transmitted row frames.
`timescale 1ns/1ps
module tb_p_2mode_1;
    import p_2mode_1_pkg::*;

    typedef struct packed {
        logic [2:0]  a;
        logic [17:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        updown = 1'b0;
    logic        P_done, RB_RW;
    logic [2:0]  RB_A;
    logic [17:0] RB_D;
    logic [17:0] RB_Q = '0;
    wire         sen, sd;

    logic tb_drv = 1'b0;
    logic tb_sen = 1'b1;
    logic tb_sd  = 1'b0;

    assign sen = tb_drv ? tb_sen : 1'bz;
    assign sd  = tb_drv ? tb_sd  : 1'bz;
    pulldown (sen);
    pullup   (sd);

    int checks = 0;
    int errors = 0;

    logic [17:0] mem [8];
    logic [2:0]  addr_d = '0;
    wr_t         wr_q[$];
    wr_t         exp_wq[$];
    logic [12:0] exp_fq[$];

    p_2mode_1 dut (
        .clk    (clk),
        .rst    (rst),
        .updown (updown),
        .P_done (P_done),
        .RB_RW  (RB_RW),
        .RB_A   (RB_A),
        .RB_D   (RB_D),
        .RB_Q   (RB_Q),
        .sen    (sen),
        .sd     (sd)
    );

    always #5 clk = ~clk;

    // Bank: read data appears one clock after the address; writes are logged for the scoreboard.
    always @(posedge clk) begin
        RB_Q   = mem[addr_d];
        addr_d = RB_A;
        if (RB_RW == 1'b0) begin
            mem[RB_A] = RB_D;
            wr_q.push_back({RB_A, RB_D});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    function automatic logic [12:0] exp_frame(input int r);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = mem[k][r];
        return {5'(r), b};
    endfunction

    task automatic drive_frame(input logic [20:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            tb_sen = 1'b0;
            tb_sd  = fr[20-i];
        end
        @(posedge clk);
        tb_sen = 1'b1;
        tb_sd  = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_write(output bit got);
        got = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (wr_q.size() != 0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Must be called at a posedge; returns at the posedge after the frame's last bit.
    task automatic get_frame(output logic [12:0] fr, output int gap, output int len, output bit ok);
        int t;
        t = 0; gap = 0; len = 0; fr = '0; ok = 1'b1;
        while (sen !== 1'b0 && t < 200) begin
            gap++;
            t++;
            @(posedge clk);
        end
        if (t >= 200) begin
            ok = 1'b0;
            return;
        end
        while (sen === 1'b0 && len < 20) begin
            fr = {fr[11:0], sd};
            len++;
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (P_done !== 1'b0) begin errors++; $display("FAIL reset_pdone: got %b, expected 0", P_done); end
        checks++; if (RB_RW !== 1'b1) begin errors++; $display("FAIL reset_rbrw: got %b, expected 1", RB_RW); end
        checks++; if (RB_A !== 3'd0) begin errors++; $display("FAIL reset_rba: got %0d, expected 0", RB_A); end
        checks++; if (RB_D !== 18'd0) begin errors++; $display("FAIL reset_rbd: got %h, expected 0", RB_D); end
        checks++; if (sen !== 1'b0) begin errors++; $display("FAIL reset_sen_hiz: got %b, expected pulled 0", sen); end
        checks++; if (sd !== 1'b1) begin errors++; $display("FAIL reset_sd_hiz: got %b, expected pulled 1", sd); end
        tb_drv = 1'b1;
        tb_sen = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_receive();
        wr_t exp, got;
        bit  ok;
        for (int c = 0; c < COL_N; c++) begin
            exp.a = 3'(c);
            exp.d = 18'h2AAAA ^ 18'(c);
            exp_wq.push_back(exp);
            drive_frame({exp.a, exp.d}, RECV_LEN);
            wait_write(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL recv_write col %0d: no write seen, expected addr %0d", c, exp.a);
                exp_wq.delete();
            end else begin
                got = wr_q.pop_front();
                exp = exp_wq.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL recv_write col %0d: got addr %0d data %h, expected addr %0d data %h",
                             c, got.a, got.d, exp.a, exp.d);
                end
            end
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL recv_extra_writes: got %0d extra writes, expected 0", wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_send_loop();
        logic [12:0] fr, exp;
        int          gap, len;
        bit          ok;
        for (int k = 0; k < 8; k++) mem[k] = 18'h3FFFF >> k;
        tb_drv = 1'b0;
        updown = 1'b1;
        for (int r = 0; r < ROW_N; r++) exp_fq.push_back(exp_frame(r));
        @(posedge clk);
        for (int r = 0; r < ROW_N; r++) begin
            get_frame(fr, gap, len, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL send_frame row %0d: no frame seen, expected one", r);
                exp_fq.delete();
                break;
            end
            exp = exp_fq.pop_front();
            checks++;
            if (fr !== exp) begin errors++; $display("FAIL send_frame row %0d: got %h, expected %h", r, fr, exp); end
            checks++;
            if (len != SEND_LEN) begin errors++; $display("FAIL send_len row %0d: got %0d, expected 13", r, len); end
            if (r > 0) begin
                checks++;
                if (gap != 10) begin errors++; $display("FAIL send_gap row %0d: got %0d, expected 10", r, gap); end
            end
        end
        checks++; if (P_done !== 1'b0) begin errors++; $display("FAIL pdone_gap: got %b, expected 0", P_done); end
        @(posedge clk);
        checks++; if (P_done !== 1'b1) begin errors++; $display("FAIL pdone_set: got %b, expected 1", P_done); end
        repeat (6) @(posedge clk);
        checks++; if (P_done !== 1'b1) begin errors++; $display("FAIL pdone_hold: got %b, expected 1", P_done); end
        checks++; if (sen !== 1'b1) begin errors++; $display("FAIL done_sen_idle: got %b, expected 1", sen); end
    endtask

    task automatic test_done_clear_partial();
        wr_t exp, got;
        bit  ok;
        @(posedge clk);
        updown = 1'b0;
        #1;
        checks++; if (sen !== 1'b0) begin errors++; $display("FAIL release_sen: got %b, expected pulled 0", sen); end
        checks++; if (sd !== 1'b1) begin errors++; $display("FAIL release_sd: got %b, expected pulled 1", sd); end
        @(posedge clk);
        checks++; if (P_done !== 1'b1) begin errors++; $display("FAIL pdone_clear_early: got %b, expected 1", P_done); end
        @(posedge clk);
        checks++; if (P_done !== 1'b0) begin errors++; $display("FAIL pdone_clear: got %b, expected 0", P_done); end
        tb_drv = 1'b1;
        tb_sen = 1'b1;
        tb_sd  = 1'b0;
        repeat (2) @(posedge clk);
        drive_frame({3'd2, 18'h0F0F0}, 10);
        exp.a = 3'd5;
        exp.d = 18'h15555;
        exp_wq.push_back(exp);
        drive_frame({exp.a, exp.d}, RECV_LEN);
        wait_write(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL partial_write: no write seen, expected addr 5");
            exp_wq.delete();
        end else begin
            got = wr_q.pop_front();
            exp = exp_wq.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL partial_write: got addr %0d data %h, expected addr %0d data %h", got.a, got.d, exp.a, exp.d);
            end
        end
        repeat (25) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL partial_extra_writes: got %0d, expected 0", wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic test_reset_mid_send();
        logic [12:0] fr, exp;
        int          gap, len, t;
        bit          ok;
        @(posedge clk);
        rst    = 1'b0;
        tb_drv = 1'b0;
        updown = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int r = 0; r < 9; r++) begin
            get_frame(fr, gap, len, ok);
            exp = exp_frame(r);
            checks++;
            if (!ok || fr !== exp) begin
                errors++;
                $display("FAIL presend row %0d: got %h (seen %0d), expected %h", r, fr, ok, exp);
                break;
            end
        end
        t = 0;
        while (sen !== 1'b0 && t < 40) begin
            t++;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        checks++; if (sen !== 1'b0) begin errors++; $display("FAIL row9_in_send: got sen %b, expected 0", sen); end
        rst = 1'b0;
        #1;
        checks++; if (P_done !== 1'b0) begin errors++; $display("FAIL midrst_pdone: got %b, expected 0", P_done); end
        checks++; if (RB_RW !== 1'b1) begin errors++; $display("FAIL midrst_rbrw: got %b, expected 1", RB_RW); end
        checks++; if (RB_A !== 3'd0) begin errors++; $display("FAIL midrst_rba: got %0d, expected 0", RB_A); end
        checks++; if (RB_D !== 18'd0) begin errors++; $display("FAIL midrst_rbd: got %h, expected 0", RB_D); end
        checks++; if (sen !== 1'b1) begin errors++; $display("FAIL midrst_sen: got %b, expected 1", sen); end
        checks++; if (sd !== 1'b0) begin errors++; $display("FAIL midrst_sd: got %b, expected 0", sd); end
        repeat (2) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        exp_fq.push_back(exp_frame(0));
        get_frame(fr, gap, len, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL restart_frame: no frame seen, expected row 0");
            exp_fq.delete();
        end else begin
            exp = exp_fq.pop_front();
            checks++;
            if (fr !== exp) begin errors++; $display("FAIL restart_frame: got %h, expected %h", fr, exp); end
            checks++;
            if (len != SEND_LEN) begin errors++; $display("FAIL restart_len: got %0d, expected 13", len); end
        end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_send_loop();
        test_done_clear_partial();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
